keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
Parametrised successor to the static all-columns-low keypad reader. It scans a ROWS x COLS switch matrix by driving one column low at a time and reading the pulled-up, active-low row inputs. Each full scan frame is debounced and decoded into a key code, press and release pulses, a multi-key flag and per-row activity levels for the LEDs. It sits between the SB_IO pull-up row inputs and the column pins in the top level, and replaces the combinational column/LED wrapper.

Parameters:
ROWS, 4, number of row inputs (>=1)
COLS, 3, number of column outputs (>=1)
SCAN_DIV, 3300, clock cycles each column is driven per frame (>=4; ~1 ms at 3.3 MHz)
DEBOUNCE, 8, consecutive identical frames required before a new key state is accepted (>=1)
CODE_W, $clog2(ROWS*COLS) (min 1), derived width of KEY_CODE; do not override

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  synchronous, active-low reset
KEYPAD_ROW_N  input  ROWS  row levels from pulled-up pins; 0 = key closed on the driven column
KEYPAD_COL_N  output  COLS  column drives; exactly one bit low outside reset
KEY_CODE  output  CODE_W  code of the accepted key, row*COLS+col
KEY_VALID  output  1  1-cycle pulse when a single key becomes accepted
KEY_RELEASE  output  1  1-cycle pulse when an accepted single key is no longer accepted
KEY_DOWN  output  1  level: exactly one key is in the accepted state
MULTI  output  1  level: two or more keys are in the accepted state
ROW_ACTIVE  output  ROWS  level: bit r = any key in row r is accepted (drives the LEDs)

Behaviour:
- Reset is synchronous and active-low: RST_N=0 sampled on a CLK edge resets everything.
- Reset values: KEYPAD_COL_N all 1, KEY_CODE 0, KEY_VALID 0, KEY_RELEASE 0, KEY_DOWN 0, MULTI 0, ROW_ACTIVE 0. Internal counters, bitmaps and sync flops are cleared to the no-key state.
- Reset mid-frame abandons the partial frame and the debounce count. No release pulse is emitted.
- Input sync: KEYPAD_ROW_N passes through 2 flops before use.
- Scan:
  - col counter 0..COLS-1 and dwell counter 0..SCAN_DIV-1.
  - The first cycle after reset release drives column 0 low (KEYPAD_COL_N = ~(1<<col)).
  - When dwell = SCAN_DIV-1, the synced rows are sampled into frame bitmap bits [r*COLS+col] = ~row[r]. Then dwell wraps to 0 and col advances; col wraps COLS-1 -> 0.
- Frame end: the sample taken at col = COLS-1 completes the frame. A frame is COLS*SCAN_DIV cycles.
- Debounce, evaluated on the cycle after frame end:
  - If frame == candidate, stable_cnt increments, saturating at DEBOUNCE.
  - Otherwise candidate <= frame and stable_cnt <= 1.
  - When stable_cnt reaches DEBOUNCE and candidate != accepted, accepted <= candidate. Events are registered the following cycle.
- Decode of accepted, with n = popcount:
  - n=0: KEY_DOWN=0, MULTI=0.
  - n=1: KEY_DOWN=1, KEY_CODE = index of the set bit.
  - n>=2: MULTI=1, KEY_DOWN=0, KEY_CODE holds its previous value.
- ROW_ACTIVE[r] = OR of accepted bits for row r. It updates in the same cycle as KEY_DOWN and MULTI.
- Events are generated on an accepted change, judged by the old vs new single-key status:
  - none or multi -> single K: KEY_VALID=1, KEY_CODE=K.
  - single -> none or multi: KEY_RELEASE=1.
  - single A -> single B: KEY_RELEASE and KEY_VALID both 1 in the same cycle, KEY_CODE=B.
  - none <-> multi: no pulses; only MULTI changes.
- Pulses last exactly 1 cycle; at most one accepted change occurs per frame.
- Latency: a clean press fully synced before a frame starts is reported DEBOUNCE frames later, +2 cycles after the last frame end.
- Bounce: any differing frame restarts the count, so glitches shorter than DEBOUNCE frames never change outputs.

Test Plan:
- Default-free config ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE=2:
  - Reset then idle -> KEYPAD_COL_N cycles 110,101,011 with a 4-cycle dwell each; all outputs 0.
  - Hold key row2/col1 -> KEY_VALID pulse with KEY_CODE=7, KEY_DOWN=1, ROW_ACTIVE=0100, within 2 frames (24 cycles) +2 cycles.
- Glitch and release:
  - Bounce row0/col0 present for 1 frame then absent -> no KEY_VALID and outputs unchanged.
  - Release after press -> single KEY_RELEASE pulse; KEY_DOWN=0; KEY_CODE stays 7.
- Key change and multi-key:
  - Slide from code 7 to code 3 directly -> KEY_RELEASE and KEY_VALID in the same cycle, KEY_CODE=3.
  - Press codes 0 and 11 together from idle -> MULTI=1, ROW_ACTIVE=1001, no pulses, KEY_DOWN=0.
  - Release one of them -> KEY_VALID with the remaining code.
- Reset mid-press: RST_N=0 for 1 cycle while KEY_DOWN=1 -> next cycle all outputs 0, KEYPAD_COL_N=111, no KEY_RELEASE; re-accepted after 2 frames.
- 4x4 variant (COLS=4, CODE_W=4): press row3/col3 -> KEY_CODE=15. Four-column rotation confirmed.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning keypad reader: drives one column low at a time and collects
// each full frame into a bitmap. Frames are debounced and decoded into a key code,
// press and release strobes, a multi-key flag and per-row activity levels.
module keypad_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 3300,
    parameter int DEBOUNCE = 8,
    parameter int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ROWS-1:0]   KEYPAD_ROW_N,
    output logic [COLS-1:0]   KEYPAD_COL_N,
    output logic [CODE_W-1:0] KEY_CODE,
    output logic              KEY_VALID,
    output logic              KEY_RELEASE,
    output logic              KEY_DOWN,
    output logic              MULTI,
    output logic [ROWS-1:0]   ROW_ACTIVE
);

    localparam int KEYS    = ROWS * COLS;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE + 1);
    localparam int POP_W   = $clog2(KEYS + 1);

    // Output handshake: KEY_VALID and KEY_RELEASE are one-cycle strobes with no
    // ready; the consumer samples them on the cycle they are high. KEY_CODE is
    // stable from a KEY_VALID cycle until the next KEY_VALID.

    logic [ROWS-1:0]   row_s1;
    logic [ROWS-1:0]   row_s2;

    logic              scan_en;
    logic [COL_W-1:0]  col;
    logic [DWELL_W-1:0] dwell;
    logic              sample;
    logic              last_col;

    logic [KEYS-1:0]   frame_acc;
    logic [KEYS-1:0]   frame_next;
    logic              frame_done;

    logic [KEYS-1:0]   candidate;
    logic [KEYS-1:0]   cand_nxt;
    logic [KEYS-1:0]   accepted;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              frame_match;
    logic              accept;
    logic              acc_chg;

    logic [POP_W-1:0]  n_keys;
    logic [CODE_W-1:0] key_idx;
    logic [ROWS-1:0]   row_any;
    logic              single;
    logic              multi_keys;

    // Two-flop synchroniser; reset value is the idle (no key) level.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= KEYPAD_ROW_N;
            row_s2 <= row_s1;
        end
    end

    assign sample   = scan_en && (dwell == DWELL_W'(SCAN_DIV - 1));
    assign last_col = (col == COL_W'(COLS - 1));

    // scan_en holds the columns released for the reset cycle itself, so column 0
    // is driven from the first cycle after reset release with a full dwell.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            scan_en <= 1'b0;
            col     <= '0;
            dwell   <= '0;
        end else begin
            scan_en <= 1'b1;
            if (scan_en) begin
                if (dwell == DWELL_W'(SCAN_DIV - 1)) begin
                    dwell <= '0;
                    col   <= last_col ? '0 : col + COL_W'(1);
                end else begin
                    dwell <= dwell + DWELL_W'(1);
                end
            end
        end
    end

    always_comb begin
        KEYPAD_COL_N = '1;
        for (int c = 0; c < COLS; c++) begin
            if (scan_en && (col == COL_W'(c))) begin
                KEYPAD_COL_N[c] = 1'b0;
            end
        end
    end

    always_comb begin
        frame_next = frame_acc;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (col == COL_W'(c)) begin
                    frame_next[r*COLS + c] = ~row_s2[r];
                end
            end
        end
    end

    // Every bit is rewritten once per frame, so frame_acc holds the complete
    // frame during the cycle frame_done is high.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            frame_acc  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= sample && last_col;
            if (sample) begin
                frame_acc <= frame_next;
            end
        end
    end

    always_comb begin
        frame_match = (frame_acc == candidate);
        cand_nxt    = frame_match ? candidate : frame_acc;
        if (!frame_match) begin
            cnt_nxt = CNT_W'(1);
        end else if (stable_cnt == CNT_W'(DEBOUNCE)) begin
            cnt_nxt = stable_cnt;
        end else begin
            cnt_nxt = stable_cnt + CNT_W'(1);
        end
        accept = (cnt_nxt == CNT_W'(DEBOUNCE)) && (cand_nxt != accepted);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            candidate  <= '0;
            stable_cnt <= '0;
            accepted   <= '0;
            acc_chg    <= 1'b0;
        end else begin
            acc_chg <= frame_done && accept;
            if (frame_done) begin
                candidate  <= cand_nxt;
                stable_cnt <= cnt_nxt;
                if (accept) begin
                    accepted <= cand_nxt;
                end
            end
        end
    end

    always_comb begin
        n_keys  = '0;
        key_idx = '0;
        for (int i = 0; i < KEYS; i++) begin
            n_keys = n_keys + POP_W'(accepted[i]);
            if (accepted[i]) begin
                key_idx = CODE_W'(i);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            row_any[r] = |accepted[r*COLS +: COLS];
        end
        single     = (n_keys == POP_W'(1));
        multi_keys = (n_keys > POP_W'(1));
    end

    // During the acc_chg cycle KEY_DOWN still reflects the previous accepted
    // bitmap, which is exactly the "old single-key" status the release needs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            KEY_CODE    <= '0;
            KEY_VALID   <= 1'b0;
            KEY_RELEASE <= 1'b0;
            KEY_DOWN    <= 1'b0;
            MULTI       <= 1'b0;
            ROW_ACTIVE  <= '0;
        end else begin
            KEY_VALID   <= acc_chg && single;
            KEY_RELEASE <= acc_chg && KEY_DOWN;
            KEY_DOWN    <= single;
            MULTI       <= multi_keys;
            ROW_ACTIVE  <= row_any;
            if (single) begin
                KEY_CODE <= key_idx;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a switch-matrix model drives the rows, a
// frame-level reference model predicts strobes and levels, and a monitor scores them.
module tb_keypad_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int KEYS     = ROWS * COLS;
    localparam int CODE_W   = 4;
    localparam int FRAME    = COLS * SCAN_DIV;
    localparam int T        = 10;
    localparam int COLS2    = 4;
    localparam int KEYS2    = ROWS * COLS2;
    localparam int EW       = 64 + 2 + CODE_W;

    localparam logic [KEYS-1:0] K0  = 12'h001;
    localparam logic [KEYS-1:0] K3  = 12'h008;
    localparam logic [KEYS-1:0] K7  = 12'h080;
    localparam logic [KEYS-1:0] K11 = 12'h800;

    // clock / reset
    logic clk = 1'b0;
    always #(T/2) clk = ~clk;
    logic rst_n;
    logic rst2_n;

    // main DUT (4x3)
    logic [KEYS-1:0]   pressed;
    logic [ROWS-1:0]   row_n;
    logic [COLS-1:0]   col_n;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_release;
    logic              key_down;
    logic              multi;
    logic [ROWS-1:0]   row_active;

    // second DUT (4x4)
    logic [KEYS2-1:0]  pressed2;
    logic [ROWS-1:0]   row_n2;
    logic [COLS2-1:0]  col_n2;
    logic [3:0]        key_code2;
    logic              key_valid2;
    logic              key_release2;
    logic              key_down2;
    logic              multi2;
    logic [ROWS-1:0]   row_active2;

    always_comb begin
        row_n = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS + c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always_comb begin
        row_n2 = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS2; c++)
                if (pressed2[r*COLS2 + c] && !col_n2[c]) row_n2[r] = 1'b0;
    end

    keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .CLK(clk), .RST_N(rst_n), .KEYPAD_ROW_N(row_n), .KEYPAD_COL_N(col_n),
        .KEY_CODE(key_code), .KEY_VALID(key_valid), .KEY_RELEASE(key_release),
        .KEY_DOWN(key_down), .MULTI(multi), .ROW_ACTIVE(row_active)
    );

    keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS2), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut2 (
        .CLK(clk), .RST_N(rst2_n), .KEYPAD_ROW_N(row_n2), .KEYPAD_COL_N(col_n2),
        .KEY_CODE(key_code2), .KEY_VALID(key_valid2), .KEY_RELEASE(key_release2),
        .KEY_DOWN(key_down2), .MULTI(multi2), .ROW_ACTIVE(row_active2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: frame-level debounce and accepted-set bookkeeping
    logic [EW-1:0]     exp_q[$];
    logic [KEYS-1:0]   m_cand;
    logic [KEYS-1:0]   m_acc;
    int                m_cnt;
    logic [CODE_W-1:0] m_code;

    function automatic logic [CODE_W-1:0] key_of(input logic [KEYS-1:0] b);
        logic [CODE_W-1:0] k = '0;
        for (int i = 0; i < KEYS; i++) if (b[i]) k = CODE_W'(i);
        return k;
    endfunction

    task automatic model_reset();
        m_cand = '0;
        m_acc  = '0;
        m_cnt  = 0;
        m_code = '0;
    endtask

    task automatic model_step(input logic [KEYS-1:0] fr, input logic [63:0] t_end);
        logic old_s;
        logic new_s;
        if (fr == m_cand) begin
            if (m_cnt < DEBOUNCE) m_cnt++;
        end else begin
            m_cand = fr;
            m_cnt  = 1;
        end
        if (m_cnt == DEBOUNCE && m_cand != m_acc) begin
            old_s = ($countones(m_acc) == 1);
            new_s = ($countones(m_cand) == 1);
            if (new_s) m_code = key_of(m_cand);
            if (old_s || new_s) exp_q.push_back({t_end + 64'(2*T), old_s, new_s, m_code});
            m_acc = m_cand;
        end
    endtask

    task automatic check_levels();
        logic [ROWS-1:0] ra;
        for (int r = 0; r < ROWS; r++) ra[r] = |m_acc[r*COLS +: COLS];
        check("key_down", key_down, ($countones(m_acc) == 1));
        check("multi", multi, ($countones(m_acc) >= 2));
        check("row_active", row_active, ra);
        check("key_code", key_code, m_code);
    endtask

    // monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (key_valid || key_release) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {key_release, key_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("event_time", $time - (T/2), e[EW-1 -: 64]);
                check("event_release", key_release, e[CODE_W+1]);
                check("event_valid", key_valid, e[CODE_W]);
                check("event_code", key_code, e[CODE_W-1:0]);
            end
        end
    end

    // driver tasks; each is entered just after a rising edge
    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_col_n", col_n, 3'b111);
        check("rst_key_code", key_code, 0);
        check("rst_outputs", {key_valid, key_release, key_down, multi}, 0);
        check("rst_row_active", row_active, 0);
        @(posedge clk);
    endtask

    task automatic run_frame(input logic [KEYS-1:0] bm);
        logic [COLS-1:0] ec;
        #1 pressed = bm;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            ec = '1;
            ec[k / SCAN_DIV] = 1'b0;
            check("col_rotation", col_n, ec);
            if (k == FRAME - 1) check_levels();
            @(posedge clk);
        end
        model_step(bm, $time);
    endtask

    task automatic run_frames(input logic [KEYS-1:0] bm, input int n);
        for (int i = 0; i < n; i++) run_frame(bm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KEYS-1:0] cur;
        int sel;
        int seen;
        logic [COLS2-1:0] ec2;

        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        pressed  = '0;
        pressed2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        run_frames('0, 2);
        run_frames(K7, 3);          // press code 7
        run_frames('0, 3);          // release
        run_frame(K0);              // one-frame bounce
        run_frames('0, 3);
        run_frames(K7, 3);
        run_frames(K3, 3);          // slide 7 -> 3
        run_frames('0, 3);
        run_frames(K0 | K11, 3);    // two keys
        run_frames(K0, 3);          // drop one
        run_frames('0, 3);

        run_frames(K7, 3);          // reset in the middle of a held press
        repeat ($urandom_range(1, FRAME - 2)) @(posedge clk);
        do_reset();
        run_frames(K7, 3);

        cur = K7;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
            end else if (sel < 6) begin
                cur = '0;
            end else if (sel < 8) begin
                cur = KEYS'(1) << $urandom_range(0, KEYS - 1);
            end else begin
                cur = (KEYS'(1) << $urandom_range(0, KEYS - 1)) | (KEYS'(1) << $urandom_range(0, KEYS - 1));
            end
            run_frame(cur);
        end
        run_frames('0, 3);
        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        // 4x4 variant: rotation over four columns and the top code
        pressed2 = 16'h8000;
        @(posedge clk);
        #1 rst2_n = 1'b1;
        @(negedge clk);
        check("dut2_rst_col_n", col_n2, 4'b1111);
        @(posedge clk);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k < 16) begin
                ec2 = '1;
                ec2[k / SCAN_DIV] = 1'b0;
                check("dut2_col_rotation", col_n2, ec2);
            end
            if (key_valid2 && seen == 0) begin
                seen = 1;
                check("dut2_latency", k, 34);
                check("dut2_code", key_code2, 15);
                check("dut2_key_down", key_down2, 1);
                check("dut2_row_active", row_active2, 4'b1000);
            end
            @(posedge clk);
        end
        check("dut2_valid_seen", seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
